// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path.
//   state_e          : run/stop state of the stopwatch
//   bcd_t            : one 4-bit BCD digit code
//   DIG_MAX_UNITS    : top value of a 0-9 digit
//   DIG_MAX_TENS_SEC : top value of the seconds-tens digit (0-5)
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,  // stopped at 00.00
      StRun   = 2'd1,
      StPause = 2'd2   // stopped, count preserved
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam int unsigned DIG_MAX_UNITS    = 9;
   localparam int unsigned DIG_MAX_TENS_SEC = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..MAX, chainable through carry.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, digit -> 0
//   clr   : synchronous clear, dominates inc
//   inc   : advance the digit by one this cycle
//   value : current digit (registered)
//   carry : inc while the digit sits at MAX (digit wraps to 0)
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX = DIG_MAX_UNITS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output bcd_t value,
   output logic carry
);

   bcd_t r_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (clr) begin
         r_value <= '0;
      end else if (inc) begin
         // >= keeps the digit inside its range even from an illegal code
         if (r_value >= bcd_t'(MAX)) begin
            r_value <= '0;
         end else begin
            r_value <= r_value + bcd_t'(1);
         end
      end
   end

   assign value = r_value;
   assign carry = inc && (r_value == bcd_t'(MAX));

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase and 4-digit BCD counter, 00.00 .. 59.99 s in hundredths.
// Optional feature macro: LAP_HOLD_EN (lap-hold display freeze on btn_lap).
// Parameters:
//   CLK_HZ  : input clock frequency
//   TICK_HZ : count rate; CLK_HZ/TICK_HZ must be an integer >= 2
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   btn_start_stop : debounced level, rising edge toggles run/stop
//   btn_clear      : debounced level, rising edge zeroes the count and stops
//   btn_lap        : debounced level, lap hold (only with LAP_HOLD_EN)
//   digit3..digit0 : seconds tens, seconds units, tenths, hundredths
//   running        : high while running
//   wrap           : one-cycle pulse on the 59.99 -> 00.00 rollover
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_start_stop,
   input  logic btn_clear,
   input  logic btn_lap,
   output bcd_t digit3,
   output bcd_t digit2,
   output bcd_t digit1,
   output bcd_t digit0,
   output logic running,
   output logic wrap
);

   localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
   localparam int unsigned PRESC_W = $clog2(DIV);

   // ---------------------------------------------------------------
   // Button synchronisers and rising-edge detection
   // ---------------------------------------------------------------
`ifdef LAP_HOLD_EN
   localparam int unsigned NBTN = 3;
   logic [NBTN-1:0] w_btn_raw;
   assign w_btn_raw = {btn_lap, btn_clear, btn_start_stop};
`else
   localparam int unsigned NBTN = 2;
   logic [NBTN-1:0] w_btn_raw;
   logic            w_unused_lap;
   assign w_btn_raw    = {btn_clear, btn_start_stop};
   assign w_unused_lap = btn_lap;
`endif

   logic [NBTN-1:0] r_sync1;
   logic [NBTN-1:0] r_sync2;
   logic [NBTN-1:0] r_prev;
   logic [NBTN-1:0] w_press;
   logic            w_ss_press;
   logic            w_clr_press;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // Press is visible after the 2nd high edge and acts on the 3rd
   assign w_press     = r_sync2 & ~r_prev;
   assign w_ss_press  = w_press[0];
   assign w_clr_press = w_press[1];

   // ---------------------------------------------------------------
   // FSM, prescaler and registered status outputs
   // ---------------------------------------------------------------
   state_e             r_state;
   logic [PRESC_W-1:0] r_presc;
   logic               r_running;
   logic               r_wrap;
   logic               w_tick;
   logic [3:0]         w_carry;

   assign w_tick = (r_state == StRun) && (r_presc == PRESC_W'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_presc   <= '0;
         r_running <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         // Clear dominates both start/stop and a coincident rollover
         r_wrap <= w_carry[3] && !w_clr_press;
         if (w_clr_press) begin
            r_state   <= StIdle;
            r_presc   <= '0;
            r_running <= 1'b0;
         end else begin
            // Prescaler holds outside RUN so a resume finishes the interval
            if (r_state == StRun) begin
               r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            end
            case (r_state)
               StIdle: begin
                  if (w_ss_press) begin
                     r_state   <= StRun;
                     r_running <= 1'b1;
                  end
               end
               StRun: begin
                  if (w_ss_press) begin
                     r_state   <= StPause;
                     r_running <= 1'b0;
                  end
               end
               StPause: begin
                  if (w_ss_press) begin
                     r_state   <= StRun;
                     r_running <= 1'b1;
                  end
               end
               default: begin
                  r_state   <= StIdle;
                  r_running <= 1'b0;
               end
            endcase
         end
      end
   end

   assign running = r_running;
   assign wrap    = r_wrap;

   // ---------------------------------------------------------------
   // BCD digit chain: hundredths -> tenths -> seconds -> tens of seconds
   // ---------------------------------------------------------------
   bcd_t w_live0;
   bcd_t w_live1;
   bcd_t w_live2;
   bcd_t w_live3;

   bcd_digit_counter #(
      .MAX (DIG_MAX_UNITS)
   ) u_dig0 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr_press),
      .inc   (w_tick),
      .value (w_live0),
      .carry (w_carry[0])
   );

   bcd_digit_counter #(
      .MAX (DIG_MAX_UNITS)
   ) u_dig1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr_press),
      .inc   (w_carry[0]),
      .value (w_live1),
      .carry (w_carry[1])
   );

   bcd_digit_counter #(
      .MAX (DIG_MAX_UNITS)
   ) u_dig2 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr_press),
      .inc   (w_carry[1]),
      .value (w_live2),
      .carry (w_carry[2])
   );

   bcd_digit_counter #(
      .MAX (DIG_MAX_TENS_SEC)
   ) u_dig3 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr_press),
      .inc   (w_carry[2]),
      .value (w_live3),
      .carry (w_carry[3])
   );

   // ---------------------------------------------------------------
   // Display path
   // ---------------------------------------------------------------
`ifdef LAP_HOLD_EN
   logic w_lap_press;
   logic r_frozen;
   bcd_t r_hold0;
   bcd_t r_hold1;
   bcd_t r_hold2;
   bcd_t r_hold3;

   assign w_lap_press = w_press[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frozen <= 1'b0;
         r_hold0  <= '0;
         r_hold1  <= '0;
         r_hold2  <= '0;
         r_hold3  <= '0;
      end else if (w_clr_press || w_ss_press) begin
         // Any press that leaves RUN (or clears) drops the freeze
         r_frozen <= 1'b0;
      end else if (w_lap_press) begin
         if (r_frozen) begin
            r_frozen <= 1'b0;
         end else if (r_state == StRun) begin
            r_frozen <= 1'b1;
            r_hold0  <= w_live0;
            r_hold1  <= w_live1;
            r_hold2  <= w_live2;
            r_hold3  <= w_live3;
         end
      end
   end

   assign digit0 = r_frozen ? r_hold0 : w_live0;
   assign digit1 = r_frozen ? r_hold1 : w_live1;
   assign digit2 = r_frozen ? r_hold2 : w_live2;
   assign digit3 = r_frozen ? r_hold3 : w_live3;
`else
   assign digit0 = w_live0;
   assign digit1 = w_live1;
   assign digit2 = w_live2;
   assign digit3 = w_live3;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter with CLK_HZ=1000, TICK_HZ=100
// (one count every 10 clocks). Digits are compared as a packed {d3,d2,d1,d0}
// BCD word, so 16'h0037 means 00.37.
module tb_stopwatch_bcd_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_start_stop = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_lap = 1'b0;
   logic [3:0] digit3;
   logic [3:0] digit2;
   logic [3:0] digit1;
   logic [3:0] digit0;
   logic       running;
   logic       wrap;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   stopwatch_bcd_counter #(
      .CLK_HZ  (1000),
      .TICK_HZ (100)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .btn_start_stop (btn_start_stop),
      .btn_clear      (btn_clear),
      .btn_lap        (btn_lap),
      .digit3         (digit3),
      .digit2         (digit2),
      .digit1         (digit1),
      .digit0         (digit0),
      .running        (running),
      .wrap           (wrap)
   );

   typedef struct {
      string       name;
      logic        ss;
      logic        clr;
      int unsigned n;      // clock edges to apply with these inputs
      logic [15:0] dig;    // expected {d3,d2,d1,d0}
      logic        run;
      logic        wrp;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs[NVEC];

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] exp_dig,
                        input logic exp_run, input logic exp_wrap);
      logic [17:0] got;
      logic [17:0] exp;
      got = {digit3, digit2, digit1, digit0, running, wrap};
      exp = {exp_dig, exp_run, exp_wrap};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got digits=%h running=%b wrap=%b, expected digits=%h running=%b wrap=%b",
                  name, got[17:2], got[1], got[0], exp_dig, exp_run, exp_wrap);
      end
   endtask

   initial begin
      vecs[0]  = '{"idle",               1'b0, 1'b0, 2,     16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{"ss_two_edges",       1'b1, 1'b0, 2,     16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{"ss_third_edge",      1'b1, 1'b0, 1,     16'h0000, 1'b1, 1'b0};
      vecs[3]  = '{"ss_held_one_press",  1'b1, 1'b0, 2,     16'h0000, 1'b1, 1'b0};
      vecs[4]  = '{"run_100_clocks",     1'b0, 1'b0, 98,    16'h0010, 1'b1, 1'b0};
      vecs[5]  = '{"run_to_0037",        1'b0, 1'b0, 273,   16'h0037, 1'b1, 1'b0};
      vecs[6]  = '{"pause_pending",      1'b1, 1'b0, 2,     16'h0037, 1'b1, 1'b0};
      vecs[7]  = '{"paused",             1'b1, 1'b0, 1,     16'h0037, 1'b0, 1'b0};
      vecs[8]  = '{"pause_hold_200",     1'b0, 1'b0, 200,   16'h0037, 1'b0, 1'b0};
      vecs[9]  = '{"resumed",            1'b1, 1'b0, 3,     16'h0037, 1'b1, 1'b0};
      vecs[10] = '{"resume_partial",     1'b1, 1'b0, 3,     16'h0037, 1'b1, 1'b0};
      vecs[11] = '{"resume_first_tick",  1'b0, 1'b0, 1,     16'h0038, 1'b1, 1'b0};
      vecs[12] = '{"run_to_5998",        1'b0, 1'b0, 59600, 16'h5998, 1'b1, 1'b0};
      vecs[13] = '{"run_to_5999",        1'b0, 1'b0, 19,    16'h5999, 1'b1, 1'b0};
      vecs[14] = '{"wrap_pulse",         1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b1};
      vecs[15] = '{"wrap_one_cycle",     1'b0, 1'b0, 1,     16'h0000, 1'b1, 1'b0};
      vecs[16] = '{"run_to_1234",        1'b0, 1'b0, 12339, 16'h1234, 1'b1, 1'b0};
      vecs[17] = '{"ss_clr_pending",     1'b1, 1'b1, 2,     16'h1234, 1'b1, 1'b0};
      vecs[18] = '{"ss_clr_clear_wins",  1'b1, 1'b1, 1,     16'h0000, 1'b0, 1'b0};
      vecs[19] = '{"idle_after_clear",   1'b0, 1'b0, 20,    16'h0000, 1'b0, 1'b0};

      // Asynchronous reset before the first clock edge
      #2 rst_n = 1'b0;
      #2 check("reset_state", 16'h0000, 1'b0, 1'b0);
      #23 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NVEC; i++) begin
         btn_start_stop = vecs[i].ss;
         btn_clear      = vecs[i].clr;
         step(vecs[i].n);
         check(vecs[i].name, vecs[i].dig, vecs[i].run, vecs[i].wrp);
      end

      // Clear press landing on a tick edge: 00.00, not 00.01
      btn_start_stop = 1'b1;
      step(3);
      check("restart", 16'h0000, 1'b1, 1'b0);
      btn_start_stop = 1'b0;
      step(7);
      btn_clear = 1'b1;
      step(3);
      check("clear_on_tick", 16'h0000, 1'b0, 1'b0);
      btn_clear = 1'b0;
      step(3);

      // Asynchronous reset mid-count, between clock edges
      btn_start_stop = 1'b1;
      step(3);
      btn_start_stop = 1'b0;
      step(25);
      check("count_before_reset", 16'h0002, 1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1 check("async_reset", 16'h0000, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      step(30);
      check("idle_after_reset", 16'h0000, 1'b0, 1'b0);
      // Prescaler must restart from 0: first count exactly 10 clocks after start
      btn_start_stop = 1'b1;
      step(3);
      btn_start_stop = 1'b0;
      step(9);
      check("presc_reset_pre", 16'h0000, 1'b1, 1'b0);
      step(1);
      check("presc_reset_tick", 16'h0001, 1'b1, 1'b0);

      // Clear while running, then lap behaviour
      btn_clear = 1'b1;
      step(3);
      check("clear_from_run", 16'h0000, 1'b0, 1'b0);
      btn_clear = 1'b0;
      step(3);
      btn_start_stop = 1'b1;
      step(3);
      btn_start_stop = 1'b0;
      step(3002);
      btn_lap = 1'b1;
      step(3);
      check("lap_press_0300", 16'h0300, 1'b1, 1'b0);
      btn_lap = 1'b0;
      step(995);
`ifdef LAP_HOLD_EN
      check("lap_frozen", 16'h0300, 1'b1, 1'b0);
`else
      check("lap_ignored", 16'h0400, 1'b1, 1'b0);
`endif
      step(1002);
      btn_lap = 1'b1;
      step(3);
      check("lap_release_0500", 16'h0500, 1'b1, 1'b0);
      btn_lap = 1'b0;
      step(5);
      check("lap_tracking_0501", 16'h0501, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
